// File: rtl/pattern_loader.sv
// Serial loader for the pattern shift chain: shifts a host-written byte image MSB-first, framed by ssel.
// Optional readback check of the old chain contents against the last loaded image: define PATTERN_VERIFY_EN.
module pattern_loader #(
    parameter int NBYTES = 27,
    parameter int AW     = 5,
    parameter int CW     = 8
) (
    input  logic          sclk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          sdo,
    output logic          sen,
    output logic          ssel,
    input  logic          sdi,
    output logic          verify_err
);

    localparam logic [1:0]    S_IDLE  = 2'd0;
    localparam logic [1:0]    S_SHIFT = 2'd1;
    localparam logic [1:0]    S_DONE  = 2'd2;
    localparam logic [CW-1:0] LAST_T  = CW'(NBYTES * 8 - 1);

    logic [7:0]    image_q [NBYTES];
    logic [7:0]    image_d [NBYTES];
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sdo_q, sdo_d;
    logic          sen_q, sen_d;
    logic          done_q, done_d;

    // Shift index t selects image byte NBYTES-1-t/8, bit 7-t%8.
    function automatic logic [AW-1:0] byte_of(input logic [CW-1:0] t);
        byte_of = AW'(NBYTES - 1 - int'(t[CW-1:3]));
    endfunction

    function automatic logic [2:0] bit_of(input logic [CW-1:0] t);
        bit_of = ~t[2:0];
    endfunction

    always_comb begin
        image_d = image_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        sdo_d   = 1'b0;
        sen_d   = 1'b0;
        done_d  = 1'b0;

        // busy freezes the image; a write on the start edge still lands in that load.
        if (wr_en && !sen_q && (int'(wr_addr) < NBYTES)) begin
            image_d[wr_addr] = wr_data;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                    sen_d   = 1'b1;
                    sdo_d   = image_d[byte_of('0)][bit_of('0)];
                end
            end
            S_SHIFT: begin
                if (cnt_q == LAST_T) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    sen_d = 1'b1;
                    sdo_d = image_q[byte_of(cnt_d)][bit_of(cnt_d)];
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NBYTES; k++) image_q[k] <= 8'h00;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sdo_q   <= 1'b0;
            sen_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            image_q <= image_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sdo_q   <= sdo_d;
            sen_q   <= sen_d;
            done_q  <= done_d;
        end
    end

    assign sdo  = sdo_q;
    assign sen  = sen_q;
    assign ssel = sen_q;
    assign busy = sen_q;
    assign done = done_q;

`ifdef PATTERN_VERIFY_EN
    logic [7:0] shadow_q [NBYTES];
    logic [7:0] shadow_d [NBYTES];
    logic       armed_q, armed_d;
    logic       verify_err_q, verify_err_d;

    // sdi carries the old chain bit leaving sout, which lines up with shadow bit t.
    always_comb begin
        shadow_d     = shadow_q;
        armed_d      = armed_q;
        verify_err_d = verify_err_q;
        if ((state_q == S_IDLE) && start) begin
            verify_err_d = 1'b0;
        end else if (sen_q && armed_q &&
                     (sdi != shadow_q[byte_of(cnt_q)][bit_of(cnt_q)])) begin
            verify_err_d = 1'b1;
        end
        if (done_d) begin
            shadow_d = image_q;
            armed_d  = 1'b1;
        end
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NBYTES; k++) shadow_q[k] <= 8'h00;
            armed_q      <= 1'b0;
            verify_err_q <= 1'b0;
        end else begin
            shadow_q     <= shadow_d;
            armed_q      <= armed_d;
            verify_err_q <= verify_err_d;
        end
    end

    assign verify_err = verify_err_q;
`else
    logic unused_sdi;
    assign unused_sdi = sdi;
    assign verify_err = 1'b0;
`endif

endmodule

// File: tb/tb_pattern_loader.sv
// Scoreboard bench for pattern_loader: stimulus pushes expected serial bits and done times, a monitor checks them.
module tb_pattern_loader;

    localparam int NB = 27;
    localparam int AW = 5;
    localparam int CW = 8;
    localparam int NBITS = NB * 8;

    logic          sclk = 1'b0;
    logic          rst_n = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [7:0]    wr_data = '0;
    logic          start = 1'b0;
    logic          busy, done, sdo, sen, ssel, sdi, verify_err;

    pattern_loader #(.NBYTES(NB), .AW(AW), .CW(CW)) dut (
        .sclk(sclk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .busy(busy), .done(done),
        .sdo(sdo), .sen(sen), .ssel(ssel), .sdi(sdi), .verify_err(verify_err)
    );

    always #5 sclk = ~sclk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge sclk) cyc <= cyc + 1;

    // Behavioural chain: shifts sdo in on qualified edges, sout is the far end.
    logic [NBITS-1:0] chain = '0;
    int corrupt_req = 0;
    int corrupt_ack = 0;
    assign sdi = chain[NBITS-1];

    always @(posedge sclk) begin
        if (corrupt_req != corrupt_ack) begin
            chain[5*8+2] <= ~chain[5*8+2];
            corrupt_ack  <= corrupt_req;
        end else if (sen) begin
            chain <= {chain[NBITS-2:0], sdo};
        end
    end

    logic [7:0] ref_img [NB];
    logic [7:0] snap    [NB];
    bit         exp_bits[$];
    int         exp_done[$];
    int         acc = -1000;
    int         done_cnt = 0;
    int         run = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every DUT output sample is compared against scoreboard contents.
    always @(negedge sclk) begin
        if (!rst_n) begin
            run = 0;
        end else begin
            if (sen) begin
                if (exp_bits.size() == 0) check("sdo_unexpected", 1, 0);
                else check("sdo_bit", int'(sdo), int'(exp_bits.pop_front()));
                run++;
            end else begin
                check("sdo_idle", int'(sdo), 0);
                if (run != 0) begin
                    check("sen_window", run, NBITS);
                    run = 0;
                end
            end
            check("busy_eq_sen", int'(busy), int'(sen));
            check("ssel_eq_sen", int'(ssel), int'(sen));
            if (done) begin
                done_cnt++;
                if (exp_done.size() == 0) check("done_unexpected", 1, 0);
                else begin
                    check("done_cycle", cyc, exp_done.pop_front());
                    check("bits_left_at_done", exp_bits.size(), 0);
                end
            end
`ifndef PATTERN_VERIFY_EN
            check("verify_err_tied", int'(verify_err), 0);
`endif
        end
    end

    // One input cycle; the reference model decides from spec timing whether the DUT accepts it.
    task automatic drive(input bit wr, input int addr, input logic [7:0] data, input bit st);
        int  e;
        bit  wr_ok, st_ok;
        e     = cyc + 1;
        wr_ok = wr && (addr < NB) && !(e >= acc + 1 && e <= acc + NBITS);
        st_ok = st && !(e >= acc + 1 && e <= acc + NBITS + 1);
        wr_en   = wr;
        wr_addr = AW'(addr);
        wr_data = data;
        start   = st;
        if (wr_ok) ref_img[addr] = data;
        if (st_ok) begin
            acc = e;
            for (int k = NB - 1; k >= 0; k--)
                for (int b = 7; b >= 0; b--)
                    exp_bits.push_back(ref_img[k][b]);
            exp_done.push_back(e + NBITS);
            for (int k = 0; k < NB; k++) snap[k] = ref_img[k];
        end
        @(negedge sclk);
        wr_en = 1'b0;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge sclk);
            n++;
        end while (!done && n < 400);
        if (!done) check("done_timeout", 0, 1);
    endtask

    task automatic check_chain();
        for (int k = 0; k < NB; k++)
            check($sformatf("chain_byte_%0d", k), int'(chain[8*k +: 8]), int'(snap[k]));
    endtask

    task automatic write_rand_image();
        for (int k = 0; k < NB; k++) drive(1'b1, k, 8'($urandom), 1'b0);
    endtask

    task automatic apply_reset();
        #3 rst_n = 1'b0;
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_sdo", int'(sdo), 0);
        check("rst_sen", int'(sen), 0);
        check("rst_ssel", int'(ssel), 0);
        check("rst_verify_err", int'(verify_err), 0);
        exp_bits.delete();
        exp_done.delete();
        acc = -1000;
        for (int k = 0; k < NB; k++) ref_img[k] = 8'h00;
        @(negedge sclk);
        @(negedge sclk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge sclk);
            check("idle_busy", int'(busy), 0);
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
        $fatal(1);
    end

    initial begin
        int d0;
        for (int k = 0; k < NB; k++) ref_img[k] = 8'h00;
        @(negedge sclk);
        apply_reset();

        // Reset clears the image: load it straight away and expect zeros on the chain.
        drive(1'b0, 0, 8'h00, 1'b1);
        wait_done();
        check_chain();

        // Basic ascending image.
        for (int k = 0; k < NB; k++) drive(1'b1, k, 8'(k), 1'b0);
        drive(1'b0, 0, 8'h00, 1'b1);
        wait_done();
        check_chain();

        // Single set bit at the first and at the last shift position.
        for (int k = 0; k < NB; k++) drive(1'b1, k, 8'h00, 1'b0);
        drive(1'b1, NB - 1, 8'h80, 1'b0);
        drive(1'b0, 0, 8'h00, 1'b1);
        wait_done();
        check_chain();
        drive(1'b1, NB - 1, 8'h00, 1'b0);
        drive(1'b1, 0, 8'h01, 1'b0);
        drive(1'b0, 0, 8'h00, 1'b1);
        wait_done();
        check_chain();

        // Write on the same edge as start is part of that load; out-of-range write is dropped.
        write_rand_image();
        drive(1'b1, NB, 8'hA5, 1'b0);
        drive(1'b1, NB - 1, 8'h3C, 1'b1);
        // Frozen image plus ignored starts during the shift window.
        repeat (3) @(negedge sclk);
        drive(1'b1, 3, 8'hFF, 1'b0);
        drive(1'b0, 0, 8'h00, 1'b1);
        repeat ($urandom_range(10, 100)) @(negedge sclk);
        drive(1'b1, 7, 8'hEE, 1'b1);
        wait_done();
        check_chain();
        // Start in the done cycle is ignored, the one after it is accepted.
        drive(1'b0, 0, 8'h00, 1'b1);
        drive(1'b0, 0, 8'h00, 1'b1);
        wait_done();
        check_chain();

        // Randomised loads with random gaps.
        for (int r = 0; r < 4; r++) begin
            write_rand_image();
            repeat ($urandom_range(0, 5)) @(negedge sclk);
            drive(1'b0, 0, 8'h00, 1'b1);
            wait_done();
            check_chain();
        end

        // Reset mid-load aborts: no done pulse, outputs clear immediately.
        write_rand_image();
        drive(1'b0, 0, 8'h00, 1'b1);
        repeat (50) @(negedge sclk);
        d0 = done_cnt;
        apply_reset();
        repeat (NBITS) @(negedge sclk);
        check("no_done_after_abort", done_cnt, d0);

`ifdef PATTERN_VERIFY_EN
        write_rand_image();
        drive(1'b0, 0, 8'h00, 1'b1);
        wait_done();
        check_chain();
        drive(1'b0, 0, 8'h00, 1'b1);
        wait_done();
        check("verify_clean", int'(verify_err), 0);
        corrupt_req++;
        repeat (3) @(negedge sclk);
        drive(1'b0, 0, 8'h00, 1'b1);
        wait_done();
        check("verify_detect", int'(verify_err), 1);
        drive(1'b0, 0, 8'h00, 1'b1);
        check("verify_clear_on_start", int'(verify_err), 0);
        wait_done();
        check("verify_clean_after", int'(verify_err), 0);
        check_chain();
`endif

        repeat (5) @(negedge sclk);
        check("exp_bits_drained", exp_bits.size(), 0);
        check("exp_done_drained", exp_done.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
